// File: rtl/mem_dump_streamer.sv
// mem_dump_streamer: post-run data-memory dump stage.
// Waits for a rising edge on the CPU finish level. It then reads every
// data-memory word in address order and streams each word out with a
// valid/ready handshake. A watchdog raises abort if finish never arrives.
//
// Ports:
//   clk, rst_n           clock (rising edge) and async active-low reset
//   finish               CPU finish level; a rising edge in IDLE starts the dump
//   mem_rd_en, mem_addr  data-memory read strobe and word address
//   mem_rdata            read data, valid one cycle after mem_rd_en
//   out_valid/out_ready  stream handshake
//   out_data, out_index  dumped word and its address
//   out_last             marks the word at address DEPTH-1
//   done, abort          sticky completion / watchdog-expiry flags
module mem_dump_streamer #(
  parameter int unsigned DEPTH          = 512,
  parameter int unsigned ADDR_W         = 9,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 300
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              finish,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              done,
  output logic              abort
);

  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [WD_W-1:0]   WD_TERM   = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, FETCH, HOLD, DONE, ABORT} stateT;

  stateT             stateQ, stateD;
  logic              finishQ;
  logic [WD_W-1:0]   watchdogQ, watchdogD;
  logic [ADDR_W-1:0] indexQ, indexD;
  logic              memRdEnD;
  logic [ADDR_W-1:0] memAddrD;
  logic              outValidD, outLastD, doneD, abortD;
  logic [DATA_W-1:0] outDataD;
  logic [ADDR_W-1:0] outIndexD;
  logic              startC;

  assign startC = finish & ~finishQ;

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ    <= IDLE;
      finishQ   <= 1'b0;
      watchdogQ <= '0;
      indexQ    <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      abort     <= 1'b0;
    end else begin
      stateQ    <= stateD;
      finishQ   <= finish;
      watchdogQ <= watchdogD;
      indexQ    <= indexD;
      mem_rd_en <= memRdEnD;
      mem_addr  <= memAddrD;
      out_valid <= outValidD;
      out_data  <= outDataD;
      out_index <= outIndexD;
      out_last  <= outLastD;
      done      <= doneD;
      abort     <= abortD;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    stateD    = stateQ;
    watchdogD = watchdogQ;
    indexD    = indexQ;
    memRdEnD  = 1'b0;
    memAddrD  = mem_addr;
    outValidD = out_valid;
    outDataD  = out_data;
    outIndexD = out_index;
    outLastD  = out_last;
    doneD     = done;
    abortD    = abort;

    unique case (stateQ)
      IDLE: begin
        watchdogD = watchdogQ + WD_W'(1);
        // A start on the terminal-count cycle takes priority over abort
        if (startC) begin
          stateD   = FETCH;
          indexD   = '0;
          memRdEnD = 1'b1;
          memAddrD = '0;
        end else if (watchdogQ == WD_TERM) begin
          stateD = ABORT;
          abortD = 1'b1;
        end
      end

      // The read strobe is registered on entry, so it is high for exactly this cycle
      FETCH: stateD = HOLD;

      HOLD: begin
        if (!out_valid) begin
          // First HOLD cycle: read data is valid now, so capture it
          outValidD = 1'b1;
          outDataD  = mem_rdata;
          outIndexD = indexQ;
          outLastD  = (indexQ == LAST_ADDR);
        end else if (out_ready) begin
          outValidD = 1'b0;
          if (out_last) begin
            doneD  = 1'b1;
            stateD = DONE;
          end else begin
            indexD   = indexQ + ADDR_W'(1);
            memRdEnD = 1'b1;
            memAddrD = indexQ + ADDR_W'(1);
            stateD   = FETCH;
          end
        end
      end

      DONE, ABORT: stateD = stateQ;

      default: stateD = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_dump_streamer.sv
module tb_mem_dump_streamer;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 32;
  localparam int          NWORDS = 512;

  logic              clk;
  logic              rst_n;
  logic              finish;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic              outReady;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;
  logic              done;
  logic              abort;

  int checks;
  int failures;

  mem_dump_streamer #(
    .DEPTH(512), .ADDR_W(9), .DATA_W(32), .TIMEOUT_CYCLES(300)
  ) dut (
    .clk(clk), .rst_n(rst_n), .finish(finish),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(outReady), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .done(done), .abort(abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory: word[i] = 3*i, returned one cycle after the strobe.
  // Junk is returned when no read is pending, so mistimed captures show up.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= DATA_W'(mem_addr) * 32'd3;
    else           mem_rdata <= 32'hDEAD_BEEF;
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Hold reset for two cycles, release on a falling edge
  task automatic doReset();
    rst_n    = 1'b0;
    finish   = 1'b0;
    outReady = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Consume a dump, checking every valid cycle against the 3*i model.
  // period: out_ready high once every 'period' cycles (1 = always).
  // toggleAt: index at which finish is dropped and raised again (-1 = never).
  // resetAt: index at which reset is pulsed while the word is valid (-1 = never).
  task automatic runDump(input int period, input int toggleAt, input int resetAt);
    int expIdx = 0;
    int nRd = 0;
    int firstValid = -1;
    int ftog = 0;
    bit over = 1'b0;
    bit gotReset = 1'b0;
    for (int it = 1; it <= 6000 && !over; it++) begin
      @(negedge clk);
      outReady = (period <= 1) || (it % period == 0);
      if (toggleAt >= 0) begin
        if (ftog == 0 && expIdx == toggleAt) begin
          finish = 1'b0;
          ftog = 1;
        end else if (ftog == 1) begin
          finish = 1'b1;
          ftog = 2;
        end
      end
      #1;
      if (mem_rd_en) begin
        nRd++;
        checkVal("rdAddr", 64'(mem_addr), 64'(nRd - 1));
      end
      if (out_valid) begin
        if (firstValid < 0) firstValid = it;
        checkVal("data", 64'(out_data), 64'(3 * expIdx));
        checkVal("index", 64'(out_index), 64'(expIdx));
        checkVal("last", 64'(out_last), 64'(expIdx == NWORDS - 1));
        if (resetAt >= 0 && expIdx == resetAt) begin
          rst_n = 1'b0;
          #1;
          checkVal("rstValid", 64'(out_valid), 64'd0);
          checkVal("rstIndex", 64'(out_index), 64'd0);
          checkVal("rstData", 64'(out_data), 64'd0);
          checkVal("rstRdEn", 64'(mem_rd_en), 64'd0);
          checkVal("rstDone", 64'(done), 64'd0);
          gotReset = 1'b1;
          over = 1'b1;
        end else if (outReady) begin
          checkVal("doneEarly", 64'(done), 64'd0);
          expIdx++;
          if (expIdx == NWORDS) over = 1'b1;
        end
      end
    end
    if (resetAt >= 0) begin
      checkVal("resetHit", 64'(gotReset), 64'd1);
    end else begin
      checkVal("wordCount", 64'(expIdx), 64'(NWORDS));
      checkVal("firstLatency", 64'(firstValid), 64'd3);
      @(negedge clk);
      #1;
      checkVal("rdCount", 64'(nRd), 64'(NWORDS));
      checkVal("doneAfterLast", 64'(done), 64'd1);
      checkVal("validAfterLast", 64'(out_valid), 64'd0);
      checkVal("abortInDump", 64'(abort), 64'd0);
    end
  endtask

  initial begin
    bit active;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    finish   = 1'b0;
    outReady = 1'b0;

    // Reset values
    @(negedge clk);
    checkVal("rstOutValid", 64'(out_valid), 64'd0);
    checkVal("rstMemRdEn", 64'(mem_rd_en), 64'd0);
    checkVal("rstDone", 64'(done), 64'd0);
    checkVal("rstAbort", 64'(abort), 64'd0);
    checkVal("rstOutData", 64'(out_data), 64'd0);
    checkVal("rstOutLast", 64'(out_last), 64'd0);

    // Plain dump: finish rises at cycle 10, consumer always ready
    doReset();
    repeat (10) @(negedge clk);
    finish = 1'b1;
    runDump(1, -1, -1);

    // Backpressure 1-of-4 plus a second finish edge at index 50
    doReset();
    repeat (3) @(negedge clk);
    finish = 1'b1;
    runDump(4, 50, -1);

    // Watchdog: finish never rises
    doReset();
    repeat (299) @(negedge clk);
    checkVal("abortBefore", 64'(abort), 64'd0);
    @(negedge clk);
    checkVal("abortAt300", 64'(abort), 64'd1);
    checkVal("doneOnAbort", 64'(done), 64'd0);
    finish = 1'b1;
    active = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid || mem_rd_en || done || !abort) active = 1'b1;
    end
    checkVal("abortQuiet", 64'(active), 64'd0);

    // Start on the watchdog terminal cycle wins over abort
    doReset();
    repeat (299) @(negedge clk);
    finish = 1'b1;
    runDump(1, -1, -1);

    // Reset mid-dump at index 100, then a fresh finish edge restarts from 0
    doReset();
    repeat (5) @(negedge clk);
    finish = 1'b1;
    runDump(4, -1, 100);
    finish = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checkVal("postRstValid", 64'(out_valid), 64'd0);
    finish = 1'b1;
    runDump(1, -1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_dump_streamer.md
Name: mem_dump_streamer

Overview:
- Post-run stage downstream of the pipelined CPU's MEM/WB stage.
- Waits for the MEM/WB `finish` indication, then reads every data-memory word in order through a read port.
- Streams each word out with a valid/ready handshake for the bench or debug UART.
- Also provides a watchdog: if `finish` never arrives within a cycle budget, the block flags an abort instead of dumping.

Parameters:
- DEPTH, 512, number of data-memory words to dump
- ADDR_W, 9, memory address width (log2 DEPTH)
- DATA_W, 32, memory word width
- TIMEOUT_CYCLES, 300, cycles after reset release to wait for finish before abort

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous active-low reset
- finish  in  1  MEM/WB finish level from CPU; rising edge starts dump
- mem_rd_en  out  1  data-memory read strobe
- mem_addr  out  ADDR_W  data-memory word address
- mem_rdata  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en
- out_valid  out  1  stream word valid
- out_ready  in  1  consumer accepts word
- out_data  out  DATA_W  dumped word
- out_index  out  ADDR_W  address of out_data
- out_last  out  1  high with the word at address DEPTH-1
- done  out  1  sticky, dump complete
- abort  out  1  sticky, watchdog expired without finish

Behaviour:
- Reset (async, rst_n=0): all outputs 0, state IDLE, index 0, watchdog 0, finish_q 0.
- Edge detect: finish_q <= finish every cycle. start = finish & ~finish_q. finish already high on the first post-reset edge counts as a start.
- States: IDLE, FETCH, HOLD, DONE, ABORT.
- IDLE:
  - watchdog increments each cycle.
  - start -> FETCH with index=0.
  - Else if watchdog == TIMEOUT_CYCLES-1 -> ABORT.
  - start and terminal count in the same cycle: start wins.
- FETCH (1 cycle):
  - mem_rd_en=1, mem_addr=index.
  - Next cycle -> HOLD.
  - On that edge: out_data<=mem_rdata (sampled in HOLD's first cycle via a capture register), out_valid<=1, out_index<=index, out_last<=(index==DEPTH-1).
- HOLD:
  - out_valid, out_data, out_index and out_last are held stable until out_ready.
  - Handshake (out_valid & out_ready) with out_last=0: out_valid<=0, index<=index+1, -> FETCH.
  - Handshake with out_last=1: out_valid<=0, done<=1, -> DONE.
- Timing: minimum throughput is 1 word per 3 cycles (FETCH, capture, HOLD handshake). Latency from start edge to first out_valid is 2 cycles.
- DONE and ABORT are terminal. Only rst_n exits them. done and abort stay high and are never both 1.
- finish edges while in FETCH, HOLD, DONE or ABORT are ignored.
- mem_rd_en is 0 outside FETCH. mem_addr holds its last value.
- index never wraps: DEPTH-1 is the final address. An index increment beyond DEPTH-1 is unreachable.
- Reset asserted mid-dump:
  - Immediate return to reset values; no partial word is held.
  - After release the block restarts in IDLE with the watchdog at 0.

Test Plan:
- Reset then finish rises at cycle 10, out_ready tied 1, memory word[i]=i*3: 512 words emitted in order with out_data[i]=3i. out_last only with out_index=511. done=1 exactly 1 cycle after the last handshake. abort=0.
- Backpressure: out_ready toggles 1-of-4 cycles: each word is held stable while out_ready=0, no word is duplicated or skipped, total count is 512, and mem_rd_en pulses exactly 512 times.
- finish never rises, TIMEOUT_CYCLES=300: abort=1 at cycle 300 after reset release. out_valid, mem_rd_en and done all stay 0 thereafter.
- finish rises exactly on watchdog terminal cycle 299: dump starts, abort stays 0.
- rst_n pulsed low while out_index=100 in HOLD: outputs clear asynchronously within the same cycle. A fresh finish edge restarts the dump from index 0.
- finish toggles again during the dump at index 50: no restart, sequence continues 51, 52, ... to 511.
